// File: rtl/cordic_share_ctrl_if.sv
// Requester-side bundle of the shared CORDIC scheduler:
// request handshake plus the broadcast response bus.
interface cordic_share_ctrl_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [32*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [31:0]           rsp_data;

    modport master (
        output req_valid, req_data,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/cordic_share_ctrl.sv
// Round-robin scheduler sharing one CORDIC core between NUM_REQ
// requesters; a tag pipe routes each result back to its issuer.
module cordic_share_ctrl #(
    parameter int NUM_REQ        = 4,
    parameter int LATENCY        = 5,
    parameter int ISSUE_INTERVAL = 1
) (
    input  logic                clk,
    input  logic                reset,
    cordic_share_ctrl_if.slave  req,
    output logic [31:0]         core_in,
    output logic                core_issue,
    input  logic [31:0]         core_out,
    output logic                busy
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SW = (ISSUE_INTERVAL > 1) ? $clog2(ISSUE_INTERVAL) : 1;

    logic [SW-1:0]      slot_q, slot_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic               gnt_vld;
    logic [IW-1:0]      gnt_id;
    logic [IW-1:0]      idx;
    logic [31:0]        gnt_data;
    logic               xfer;
    logic [NUM_REQ-1:0] ready;

    logic [31:0]        core_in_q;
    logic               issue_q;
    logic [IW-1:0]      issue_id_q;
    logic [LATENCY-1:0] tag_v_q;
    logic [IW-1:0]      tag_id_q [LATENCY];
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_data_q;

    always_comb begin
        slot_d = slot_q + SW'(1);
        if (slot_q == SW'(ISSUE_INTERVAL - 1)) slot_d = '0;
    end

    // First valid requester at or above rr_q, wrapping.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IW'((int'(rr_q) + k) % NUM_REQ);
            if (!gnt_vld && req.req_valid[idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = idx;
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_id == IW'(i)) gnt_data = req.req_data[32*i +: 32];
        end
    end

    always_comb begin
        ready = '0;
        xfer  = gnt_vld && (slot_q == '0) && !reset;
        if (xfer) ready[gnt_id] = 1'b1;
    end

    always_comb begin
        rr_d = rr_q;
        if (xfer) begin
            rr_d = (gnt_id == IW'(NUM_REQ - 1)) ? '0 : gnt_id + IW'(1);
        end
    end

    always_comb begin
        rsp_valid_d = '0;
        if (tag_v_q[LATENCY-1]) rsp_valid_d[tag_id_q[LATENCY-1]] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q      <= '0;
            rr_q        <= '0;
            core_in_q   <= '0;
            issue_q     <= 1'b0;
            issue_id_q  <= '0;
            tag_v_q     <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            for (int k = 0; k < LATENCY; k++) tag_id_q[k] <= '0;
        end else begin
            slot_q      <= slot_d;
            rr_q        <= rr_d;
            issue_q     <= xfer;
            if (xfer) begin
                core_in_q  <= gnt_data;
                issue_id_q <= gnt_id;
            end
            // Head follows the issue strobe; tail lines up with core_out.
            tag_v_q[0]  <= issue_q;
            tag_id_q[0] <= issue_id_q;
            for (int k = 1; k < LATENCY; k++) begin
                tag_v_q[k]  <= tag_v_q[k-1];
                tag_id_q[k] <= tag_id_q[k-1];
            end
            rsp_valid_q <= rsp_valid_d;
            if (tag_v_q[LATENCY-1]) rsp_data_q <= core_out;
        end
    end

    assign req.req_ready = ready;
    assign req.rsp_valid = rsp_valid_q;
    assign req.rsp_data  = rsp_data_q;
    assign core_in       = core_in_q;
    assign core_issue    = issue_q;
    assign busy          = issue_q | (|tag_v_q);
endmodule

// File: tb/tb_cordic_share_ctrl.sv
// Scoreboard bench: pipelined (II=1) and iterative (II=5) instances,
// each paired with a behavioural core model.
module tb_cordic_share_ctrl;
    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    cordic_share_ctrl_if #(.NUM_REQ(4)) ifa ();
    cordic_share_ctrl_if #(.NUM_REQ(4)) ifb ();

    logic [31:0] core_in_a, core_out_a, core_in_b, core_out_b;
    logic        core_issue_a, core_issue_b, busy_a, busy_b;

    cordic_share_ctrl #(.NUM_REQ(4), .LATENCY(5), .ISSUE_INTERVAL(1)) dut_a (
        .clk(clk), .reset(rst_a), .req(ifa.slave),
        .core_in(core_in_a), .core_issue(core_issue_a),
        .core_out(core_out_a), .busy(busy_a)
    );

    cordic_share_ctrl #(.NUM_REQ(4), .LATENCY(5), .ISSUE_INTERVAL(5)) dut_b (
        .clk(clk), .reset(rst_b), .req(ifb.slave),
        .core_in(core_in_b), .core_issue(core_issue_b),
        .core_out(core_out_b), .busy(busy_b)
    );

    function automatic logic [31:0] fcore(input logic [31:0] x);
        return {x[7:0], x[31:8]} ^ 32'h3C5A_96E1;
    endfunction

    // Core models: result appears 5 cycles after the issue cycle; never reset.
    logic [4:0]  cva = '0, cvb = '0;
    logic [31:0] cda [5];
    logic [31:0] cdb [5];
    always @(posedge clk) begin
        cva    <= {cva[3:0], core_issue_a};
        cvb    <= {cvb[3:0], core_issue_b};
        cda[0] <= fcore(core_in_a);
        cdb[0] <= fcore(core_in_b);
        for (int i = 1; i < 5; i++) begin
            cda[i] <= cda[i-1];
            cdb[i] <= cdb[i-1];
        end
    end
    assign core_out_a = cva[4] ? cda[4] : 32'hDEAD_BEEF;
    assign core_out_b = cvb[4] ? cdb[4] : 32'hDEAD_BEEF;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    typedef struct {
        int          due;
        int          id;
        logic [31:0] data;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    exp_t        e;
    logic        rst_seen_a = 1'b1;
    logic        prev_x = 1'b0;
    logic [31:0] prev_d = '0;
    logic [3:0]  xm_a = '0;
    logic [3:0]  xm_b = '0;
    logic [3:0]  va = '0;
    logic [3:0]  vb = '0;
    logic [31:0] da [4];
    int          rr = 0;
    int          sb = 0;
    int          lastg = -1;

    always @(posedge clk) rst_seen_a <= rst_a;

    // Instance A reference: round-robin from rr, response due 7 cycles later.
    always @(negedge clk) begin
        logic [3:0] exp_rv, exp_ry;
        int g, j;
        exp_rv = '0;
        if (qa.size() != 0 && qa[0].due == cyc) exp_rv = 4'(1 << qa[0].id);
        chk("a_rsp_valid", 32'(ifa.rsp_valid), 32'(exp_rv));
        if (exp_rv != 0) begin
            e = qa.pop_front();
            chk("a_rsp_data", ifa.rsp_data, e.data);
        end
        chk("a_busy", 32'(busy_a), 32'(qa.size() != 0));
        chk("a_issue", 32'(core_issue_a), 32'(prev_x));
        if (prev_x) chk("a_core_in", core_in_a, prev_d);
        if (rst_seen_a) begin
            chk("a_rst_rsp_data", ifa.rsp_data, 32'h0);
            if (!prev_x) chk("a_rst_core_in", core_in_a, 32'h0);
        end
        g = -1;
        for (int k = 0; k < 4; k++) begin
            j = (rr + k) % 4;
            if (g < 0 && ifa.req_valid[j]) g = j;
        end
        exp_ry = (!rst_a && g >= 0) ? 4'(1 << g) : 4'h0;
        chk("a_ready", 32'(ifa.req_ready), 32'(exp_ry));
        xm_a   = exp_ry;
        prev_x = 1'b0;
        if (rst_a) begin
            qa.delete();
            rr = 0;
        end else if (g >= 0) begin
            qa.push_back('{cyc + 7, g, fcore(da[g])});
            rr     = (g + 1) % 4;
            prev_x = 1'b1;
            prev_d = da[g];
        end
    end

    // Instance B reference: issue only every 5th cycle after reset.
    always @(negedge clk) begin
        logic [3:0] exp_rv, exp_ry;
        exp_rv = '0;
        if (qb.size() != 0 && qb[0].due == cyc) exp_rv = 4'b0100;
        chk("b_rsp_valid", 32'(ifb.rsp_valid), 32'(exp_rv));
        if (exp_rv != 0) begin
            e = qb.pop_front();
            chk("b_rsp_data", ifb.rsp_data, e.data);
        end
        chk("b_busy", 32'(busy_b), 32'(qb.size() != 0));
        exp_ry = (!rst_b && sb == 0 && ifb.req_valid[2]) ? 4'b0100 : 4'h0;
        chk("b_ready", 32'(ifb.req_ready), 32'(exp_ry));
        xm_b = exp_ry;
        if (exp_ry != 0) begin
            if (lastg >= 0) chk("b_spacing", 32'(cyc - lastg), 32'd5);
            lastg = cyc;
            qb.push_back('{cyc + 7, 2, fcore(ifb.req_data[95:64])});
        end
        if (rst_b) begin
            qb.delete();
            lastg = -1;
        end
        sb = rst_b ? 0 : (sb + 1) % 5;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_a();
        ifa.req_valid = va;
        for (int i = 0; i < 4; i++) ifa.req_data[32*i +: 32] = da[i];
    endtask

    // Granted or idle requesters get fresh data; waiting ones hold theirs.
    task automatic next_a(input logic [3:0] want);
        for (int i = 0; i < 4; i++) begin
            if (xm_a[i] || !va[i]) da[i] = $urandom;
        end
        va = want;
        apply_a();
        tick();
    endtask

    initial begin
        logic [3:0] w;
        for (int i = 0; i < 4; i++) da[i] = $urandom;
        va = 4'hF;
        apply_a();
        ifb.req_valid = '0;
        ifb.req_data  = '0;
        repeat (3) tick();
        rst_a = 1'b0;
        repeat (12) next_a(4'hF);
        repeat (10) next_a(4'h0);

        da[0] = 32'h3F00_0000;
        va = 4'h1;
        apply_a();
        tick();
        repeat (10) next_a(4'h0);

        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        next_a(4'b0010);
        repeat (6) next_a(4'b1010);
        repeat (8) next_a(4'h0);

        repeat (300) begin
            for (int i = 0; i < 4; i++) begin
                if (va[i] && !xm_a[i]) w[i] = ($urandom_range(9) != 0);
                else                   w[i] = ($urandom_range(1) != 0);
            end
            next_a(w);
        end

        repeat (3) next_a(4'hF);
        rst_a = 1'b1;
        va = 4'h0;
        apply_a();
        tick();
        rst_a = 1'b0;
        repeat (20) next_a(4'h0);

        rst_b = 1'b0;
        vb = 4'b0100;
        ifb.req_valid = vb;
        ifb.req_data[95:64] = $urandom;
        repeat (40) begin
            tick();
            if (xm_b[2]) ifb.req_data[95:64] = $urandom;
        end
        ifb.req_valid = '0;
        repeat (15) tick();

        @(negedge clk);
        #1;
        chk("a_queue_drained", 32'(qa.size()), 32'd0);
        chk("b_queue_drained", 32'(qb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
